// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a song held in an external synchronous ROM
// and drives the tone generator's one-hot key vector. Each note is held for
// duration x TICKS_PER_BEAT cycles and is followed by GAP_TICKS silent cycles.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, stop     one-cycle pulses: begin playback from address 0 / abort
//   loop_en         level: restart the song at its end instead of finishing
//   keys_in[9:0]    front-panel keys (only used with MANUAL_OVERRIDE_EN)
//   song_addr       ROM address; song_data (8b) is valid one cycle later
//   note_bits[9:0]  one-hot key vector to the tone generator
//   sound_en        speaker gate (an all-zero key vector is not silent)
//   busy            high whenever not IDLE
//   done            one-cycle pulse on normal end of song
//
// Optional feature: define MANUAL_OVERRIDE_EN to let held front-panel keys
// override the sequencer output (lowest pressed key wins).
module melody_sequencer #(
    parameter int unsigned TICKS_PER_BEAT = 250000,
    parameter int unsigned GAP_TICKS      = 20000,
    parameter int unsigned SONG_LEN       = 64,
    localparam int unsigned ADDR_W        = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [9:0]        keys_in,
    output logic [ADDR_W-1:0] song_addr,
    input  logic [7:0]        song_data,
    output logic [9:0]        note_bits,
    output logic              sound_en,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] END_CODE = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       tick_q, tick_d;
    logic [4:0]        beat_q, beat_d;
    logic [4:0]        dur_q, dur_d;
    logic [ADDR_W-1:0] addr_d;
    logic [9:0]        seq_note_q, seq_note_d;
    logic              seq_sound_q, seq_sound_d;
    logic              done_d;
    logic              end_c;
    logic [3:0]        code_c;
    logic [9:0]        decoded_note_c;
    logic              decoded_sound_c;

    // Note code decode: 1..10 are keys, everything else is silent.
    always_comb begin
        code_c          = song_data[3:0];
        decoded_note_c  = 10'd0;
        decoded_sound_c = 1'b0;
        if (code_c >= 4'd1 && code_c <= 4'd10) begin
            decoded_note_c  = 10'd1 << (code_c - 4'd1);
            decoded_sound_c = 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = song_addr;
        seq_note_d  = seq_note_q;
        seq_sound_d = seq_sound_q;
        dur_d       = dur_q;
        done_d      = 1'b0;
        end_c       = 1'b0;
        // Counters restart on every state entry; staying states override.
        tick_d      = 32'd0;
        beat_d      = 5'd0;

        case (state_q)
            IDLE: begin
                addr_d      = '0;
                seq_note_d  = 10'd0;
                seq_sound_d = 1'b0;
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (code_c == END_CODE) begin
                    end_c = 1'b1;
                end else begin
                    state_d     = PLAY;
                    seq_note_d  = decoded_note_c;
                    seq_sound_d = decoded_sound_c;
                    dur_d       = (song_data[7:4] == 4'd0) ? 5'd16 : {1'b0, song_data[7:4]};
                end
            end
            PLAY: begin
                if (tick_q == 32'(TICKS_PER_BEAT - 1)) begin
                    if (beat_q == dur_q - 5'd1) begin
                        state_d     = GAP;
                        seq_note_d  = 10'd0;
                        seq_sound_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                    beat_d = beat_q;
                end
            end
            GAP: begin
                if (tick_q == 32'(GAP_TICKS - 1)) begin
                    if (song_addr == ADDR_W'(SONG_LEN - 1)) begin
                        end_c = 1'b1;
                    end else begin
                        addr_d  = song_addr + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of song is resolved in the cycle it is detected.
        if (end_c) begin
            addr_d = '0;
            if (loop_en) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort has priority over everything, including a same-cycle start.
        if (stop) begin
            state_d     = IDLE;
            addr_d      = '0;
            seq_note_d  = 10'd0;
            seq_sound_d = 1'b0;
            done_d      = 1'b0;
            tick_d      = 32'd0;
            beat_d      = 5'd0;
        end
    end

    // State and sequencer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= 32'd0;
            beat_q      <= 5'd0;
            dur_q       <= 5'd0;
            song_addr   <= '0;
            seq_note_q  <= 10'd0;
            seq_sound_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            beat_q      <= beat_d;
            dur_q       <= dur_d;
            song_addr   <= addr_d;
            seq_note_q  <= seq_note_d;
            seq_sound_q <= seq_sound_d;
            busy        <= (state_d != IDLE);
            done        <= done_d;
        end
    end

`ifdef MANUAL_OVERRIDE_EN
    // Held keys replace the sequencer output; lowest pressed key wins.
    logic [9:0] key_low_c;
    assign key_low_c = keys_in & (~keys_in + 10'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_bits <= 10'd0;
            sound_en  <= 1'b0;
        end else if (keys_in != 10'd0) begin
            note_bits <= key_low_c;
            sound_en  <= 1'b1;
        end else begin
            note_bits <= seq_note_d;
            sound_en  <= seq_sound_d;
        end
    end
`else
    // Keys are ignored in this build; the port remains for pin compatibility.
    logic unused_keys;
    assign unused_keys = ^keys_in;
    assign note_bits   = seq_note_q;
    assign sound_en    = seq_sound_q;
`endif

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored tune on the piano tone generator by fetching note entries from an external synchronous song ROM and driving the generator's 10-bit one-hot key vector for a timed number of beats, with a fixed silent gap between notes. It sits between the song ROM / front-panel keys and the tone generator. It also provides `sound_en` to gate the speaker, because an all-zero key vector makes the generator produce its default high tone rather than silence.

## Interface
- `TICKS_PER_BEAT`, default 250000: clk cycles per beat (125 ms at the 2 MHz tone clock).
- `GAP_TICKS`, default 20000: silent clk cycles after every note or rest.
- `SONG_LEN`, default 64: number of ROM entries; address width is `ADDR_W = clog2(SONG_LEN)`.
- `clk` in 1: system clock (2 MHz), rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins playback at address 0 when IDLE.
- `stop` in 1: one-cycle pulse; aborts playback.
- `loop_en` in 1: level; restart at address 0 at end of song instead of finishing.
- `keys_in` in 10: front-panel keys, bit 0 = Low F … bit 9 = High C.
- `song_addr` out ADDR_W: ROM address.
- `song_data` in 8: ROM data, valid one cycle after `song_addr`. Bits [3:0] are the note code; bits [7:4] are the duration in beats.
- `note_bits` out 10: one-hot key vector to the tone generator.
- `sound_en` out 1: speaker gate, 1 = audible.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal end of song.

## Operation
- Note codes:
  - 1..10 select the one-hot bit (code−1).
  - 0 and 11..14 are rests: `note_bits`=0, `sound_en`=0.
  - 15 is the end marker.
- Duration field 0 means 16 beats.
- State IDLE: `song_addr` held at 0. On `start` go to FETCH.
- State FETCH (1 cycle): `song_addr` is presented.
- State LOAD (1 cycle): sample `song_data`.
  - Code 15 → END.
  - Otherwise go to PLAY and register `note_bits`/`sound_en` from the code.
- State PLAY: hold the outputs for duration×`TICKS_PER_BEAT` cycles, then go to GAP.
- State GAP: `note_bits`=0 and `sound_en`=0 for `GAP_TICKS` cycles.
  - If `song_addr`=`SONG_LEN`−1 → END (address never wraps silently).
  - Otherwise increment `song_addr` → FETCH.
- END (evaluated in the same cycle the end condition is detected):
  - `loop_en`=1: `song_addr`←0, go to FETCH, no `done`.
  - `loop_en`=0: `done` pulses for one cycle, go to IDLE.
- `stop` in any state: next state IDLE, `note_bits`/`sound_en`/`song_addr` cleared, no `done`.
- Simultaneous events:
  - `stop` together with `start`: stop wins.
  - `start` while `busy`: ignored.
- Counters: the tick counter is 32-bit and the beat counter is 5-bit. Both are cleared on every state entry.

## Timing
- Reset values: `song_addr`=0, `note_bits`=0, `sound_en`=0, `busy`=0, `done`=0, state IDLE. All outputs are registered.
- `start` sampled at edge 0 → FETCH at edge 1 → LOAD at edge 2 → note outputs valid after edge 3.
- A note of d beats is audible for exactly d×`TICKS_PER_BEAT` cycles. It is followed by exactly `GAP_TICKS` silent cycles, then 2 cycles (FETCH, LOAD) before the next note.
- `busy` rises the cycle after `start` is sampled.
- On normal end, `busy` falls in the same cycle `done` is high.
- `stop` clears the outputs one cycle after it is sampled.
- Reset asserted mid-note forces the reset values immediately (asynchronous).

## Configuration
- `MANUAL_OVERRIDE_EN` defined:
  - If `keys_in` is nonzero, the next cycle drives `note_bits` = the lowest set bit of `keys_in` and `sound_en`=1, overriding the sequencer.
  - The sequencer keeps advancing underneath. When the keys are released, the sequencer's current outputs reappear the next cycle.
  - Works in IDLE too (free play).
- `MANUAL_OVERRIDE_EN` undefined: `keys_in` is ignored; the port is still present.

## Test plan
Bench parameters: `TICKS_PER_BEAT`=4, `GAP_TICKS`=2, `SONG_LEN`=8.
- Reset: assert `rst` mid-PLAY → all outputs 0 immediately; `busy`=0 after release.
- ROM {0x25, 0x1A, 0x0F}, pulse `start` → the following sequence, then `done`=1 for 1 cycle and `busy`=0:
  - 3 cycles later `note_bits`=0x010, `sound_en`=1 for 8 cycles.
  - 2 silent cycles, then 2 fetch cycles.
  - `note_bits`=0x200 for 4 cycles, then 2 silent cycles.
- ROM {0x30, 0x0F} → `sound_en`=0 for the whole 12-cycle rest; `done` pulses.
- ROM with no end marker (8 × 0x11) → plays addresses 0..7, then `done`; `song_addr` returns to 0.
- `stop` during the second note of the tune above → next cycle `note_bits`=0, `sound_en`=0, `busy`=0, no `done`. `start`+`stop` in the same cycle → stays IDLE.
- `loop_en`=1 with ROM {0x14, 0x0F} → after the gap, `song_addr` returns to 0 and 0x008 replays; `done` never pulses.
- With `MANUAL_OVERRIDE_EN`: `keys_in`=0x005 during a note → next cycle `note_bits`=0x001, `sound_en`=1. `keys_in`=0 → sequencer note restored next cycle.
